// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
//  Module      : dmem_port_arbiter_if
//  Description : Bus bundle between the data-memory port arbiter, its two
//                requesters (operand-fetch read, write-back write) and the
//                data SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  // Read requester
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  // Write requester
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  // Data SRAM
  logic [ADDR_WIDTH-1:0] addr_1;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we_n;

  // Arbiter side
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, data_in,
    output rd_gnt, rd_data, rd_valid, wr_gnt, addr_1, data_out, we_n
  );

  // Requester / SRAM side
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, data_in,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, addr_1, data_out, we_n
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Arbitrates one single-port data SRAM between a read
//                requester and a write requester. Writes win by default
//                (store-before-load), but a pending read is forced through
//                after STARVE_LIMIT consecutive write grants.
//                Optional macro DMEM_ARB_BYPASS_EN merges a same-address read
//                into the winning WRITE cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  wire                logic clk,
  input  wire                logic reset_n,
  dmem_port_arbiter_if.slave bus
);

`ifdef DMEM_ARB_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  localparam logic [2:0] c_STARVE_LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  we_n_q, we_n_d;
  logic                  rd_gnt_q, rd_gnt_d;
  logic                  wr_gnt_q, wr_gnt_d;
  logic                  merge_q, merge_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [2:0]            streak_q, streak_d;

  logic                  wr_wins;
  logic                  same_addr;

  assign wr_wins   = bus.wr_req && (!bus.rd_req || (streak_q != c_STARVE_LIMIT));
  assign same_addr = (bus.rd_addr == bus.wr_addr);

  // Next-state: retire the current access, then pick the next one.
  always_comb begin
    state_d    = ST_IDLE;
    addr_d     = addr_q;
    dout_d     = dout_q;
    we_n_d     = 1'b1;
    rd_gnt_d   = 1'b0;
    wr_gnt_d   = 1'b0;
    merge_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    streak_d   = streak_q;

    // The SRAM read is asynchronous, so data_in is captured at the edge that
    // closes the READ cycle; a merged read returns the data being written.
    if (state_q == ST_READ) begin
      rd_valid_d = 1'b1;
      rd_data_d  = bus.data_in;
    end else if ((state_q == ST_WRITE) && merge_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = dout_q;
    end

    if (wr_wins) begin
      state_d  = ST_WRITE;
      addr_d   = bus.wr_addr;
      dout_d   = bus.wr_data;
      we_n_d   = 1'b0;
      wr_gnt_d = 1'b1;
      if (c_BYPASS && bus.rd_req && same_addr) begin
        merge_d  = 1'b1;
        rd_gnt_d = 1'b1;
        streak_d = 3'd0;
      end else if (bus.rd_req) begin
        // Read was passed over: count it, saturating at the limit.
        streak_d = (streak_q == c_STARVE_LIMIT) ? streak_q : streak_q + 3'd1;
      end else begin
        streak_d = 3'd0;
      end
    end else if (bus.rd_req) begin
      state_d  = ST_READ;
      addr_d   = bus.rd_addr;
      rd_gnt_d = 1'b1;
      streak_d = 3'd0;
    end else begin
      streak_d = 3'd0;
    end
  end

  // State and registered SRAM/handshake outputs; reset abandons any access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      dout_q     <= '0;
      we_n_q     <= 1'b1;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      merge_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      streak_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      we_n_q     <= we_n_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      merge_q    <= merge_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      streak_q   <= streak_d;
    end
  end

  assign bus.addr_1   = addr_q;
  assign bus.data_out = dout_q;
  assign bus.we_n     = we_n_q;
  assign bus.rd_gnt   = rd_gnt_q;
  assign bus.wr_gnt   = wr_gnt_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Directed self-checking bench for dmem_port_arbiter with a
//                behavioural asynchronous-read data SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  logic [15:0] mem [0:255];

  dmem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  dmem_port_arbiter #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (16),
    .STARVE_LIMIT(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write SRAM model
  assign bus.data_in = mem[bus.addr_1[7:0]];
  always @(posedge clk) begin
    if (!bus.we_n) mem[bus.addr_1[7:0]] <= bus.data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got=%0h exp=1", bus.we_n); end
    checks++; if (bus.addr_1 !== 16'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", bus.addr_1); end
    checks++; if (bus.data_out !== 16'h0) begin errors++; $display("FAIL rst_dout got=%0h exp=0", bus.data_out); end
    checks++; if ({bus.rd_gnt, bus.wr_gnt, bus.rd_valid} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.rd_gnt, bus.wr_gnt, bus.rd_valid}); end
    checks++; if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL rst_rdata got=%0h exp=0", bus.rd_data); end
    reset_n = 1'b1;
    tick();
    checks++; if ({bus.rd_gnt, bus.wr_gnt, bus.we_n} !== 3'b001) begin errors++; $display("FAIL idle_after_rst got=%b exp=001", {bus.rd_gnt, bus.wr_gnt, bus.we_n}); end
  endtask

  task automatic test_single_read();
    bus.rd_req = 1'b1; bus.rd_addr = 16'h0010;
    tick();
    checks++; if ({bus.rd_gnt, bus.wr_gnt, bus.we_n} !== 3'b101) begin errors++; $display("FAIL rd_gnt got=%b exp=101", {bus.rd_gnt, bus.wr_gnt, bus.we_n}); end
    checks++; if (bus.addr_1 !== 16'h0010) begin errors++; $display("FAIL rd_addr got=%0h exp=10", bus.addr_1); end
    bus.rd_req = 1'b0;
    tick();
    checks++; if ({bus.rd_valid, bus.rd_gnt} !== 2'b10) begin errors++; $display("FAIL rd_valid got=%b exp=10", {bus.rd_valid, bus.rd_gnt}); end
    checks++; if (bus.rd_data !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%0h exp=beef", bus.rd_data); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 16'hBEEF) begin errors++; $display("FAIL rd_data_hold got=%0h exp=beef", bus.rd_data); end
  endtask

  task automatic test_single_write();
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0020; bus.wr_data = 16'h1234;
    tick();
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b100) begin errors++; $display("FAIL wr_gnt got=%b exp=100", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    checks++; if (bus.addr_1 !== 16'h0020) begin errors++; $display("FAIL wr_addr got=%0h exp=20", bus.addr_1); end
    checks++; if (bus.data_out !== 16'h1234) begin errors++; $display("FAIL wr_dout got=%0h exp=1234", bus.data_out); end
    bus.wr_req = 1'b0;
    tick();
    checks++; if (mem[8'h20] !== 16'h1234) begin errors++; $display("FAIL wr_sram got=%0h exp=1234", mem[8'h20]); end
    checks++; if ({bus.wr_gnt, bus.we_n} !== 2'b01) begin errors++; $display("FAIL wr_end got=%b exp=01", {bus.wr_gnt, bus.we_n}); end
    checks++; if (bus.addr_1 !== 16'h0020) begin errors++; $display("FAIL idle_addr_hold got=%0h exp=20", bus.addr_1); end
  endtask

  task automatic test_contention();
    bus.rd_req = 1'b1; bus.rd_addr = 16'h0040;
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0050; bus.wr_data = 16'h5555;
    tick();
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b100) begin errors++; $display("FAIL cont_w got=%b exp=100", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    checks++; if (bus.addr_1 !== 16'h0050) begin errors++; $display("FAIL cont_waddr got=%0h exp=50", bus.addr_1); end
    bus.wr_req = 1'b0;
    tick();
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b011) begin errors++; $display("FAIL cont_r got=%b exp=011", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    checks++; if (bus.addr_1 !== 16'h0040) begin errors++; $display("FAIL cont_raddr got=%0h exp=40", bus.addr_1); end
    bus.rd_req = 1'b0;
    tick();
    checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'h4444}) begin errors++; $display("FAIL cont_rdata got=%b/%0h exp=1/4444", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_starvation();
    // Expected grant per cycle, encoded {wr_gnt, rd_gnt}: W,W,W,R,W,idle
    logic [1:0] exp_seq [0:5];
    int         wr_grants;
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10;
    exp_seq[3] = 2'b01; exp_seq[4] = 2'b10; exp_seq[5] = 2'b00;
    wr_grants = 0;
    bus.rd_req = 1'b1; bus.rd_addr = 16'h0060;
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0070; bus.wr_data = 16'h7000;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({bus.wr_gnt, bus.rd_gnt} !== exp_seq[i]) begin
        errors++;
        $display("FAIL starve_cycle%0d got=%b exp=%b", i, {bus.wr_gnt, bus.rd_gnt}, exp_seq[i]);
      end
      if (bus.rd_gnt) bus.rd_req = 1'b0;
      if (bus.wr_gnt) begin
        wr_grants++;
        bus.wr_data = bus.wr_data + 16'h1;
        if (wr_grants == 4) bus.wr_req = 1'b0;
      end
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b0, 16'h6666}) begin errors++; $display("FAIL starve_rdata got=%b/%0h exp=0/6666", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_same_addr();
    bus.rd_req = 1'b1; bus.rd_addr = 16'h0030;
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0030; bus.wr_data = 16'h5A5A;
    tick();
`ifdef DMEM_ARB_BYPASS_EN
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b110) begin errors++; $display("FAIL same_merged got=%b exp=110", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    tick();
    checks++; if ({bus.wr_gnt, bus.rd_gnt} !== 2'b00) begin errors++; $display("FAIL same_no_read got=%b exp=00", {bus.wr_gnt, bus.rd_gnt}); end
`else
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b100) begin errors++; $display("FAIL same_w got=%b exp=100", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    bus.wr_req = 1'b0;
    tick();
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.addr_1} !== {2'b01, 16'h0030}) begin errors++; $display("FAIL same_r got=%b/%0h exp=01/30", {bus.wr_gnt, bus.rd_gnt}, bus.addr_1); end
    bus.rd_req = 1'b0;
    tick();
`endif
    checks++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'h5A5A}) begin errors++; $display("FAIL same_rdata got=%b/%0h exp=1/5a5a", bus.rd_valid, bus.rd_data); end
    tick();
  endtask

  task automatic test_reset_during_write();
    bus.wr_req = 1'b1; bus.wr_addr = 16'h0080; bus.wr_data = 16'hAAAA;
    tick();
    checks++; if ({bus.wr_gnt, bus.we_n} !== 2'b10) begin errors++; $display("FAIL rdw_write got=%b exp=10", {bus.wr_gnt, bus.we_n}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b001) begin errors++; $display("FAIL rdw_async got=%b exp=001", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    checks++; if ({bus.addr_1, bus.data_out} !== 32'h0) begin errors++; $display("FAIL rdw_bus got=%0h/%0h exp=0/0", bus.addr_1, bus.data_out); end
    bus.wr_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if ({bus.wr_gnt, bus.rd_gnt, bus.we_n} !== 3'b001) begin errors++; $display("FAIL rdw_idle got=%b exp=001", {bus.wr_gnt, bus.rd_gnt, bus.we_n}); end
    checks++; if (mem[8'h80] !== 16'h0) begin errors++; $display("FAIL rdw_sram got=%0h exp=0", mem[8'h80]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h40] = 16'h4444;
    mem[8'h60] = 16'h6666;
    reset_n     = 1'b0;
    bus.rd_req  = 1'b0; bus.rd_addr = 16'h0;
    bus.wr_req  = 1'b0; bus.wr_addr = 16'h0; bus.wr_data = 16'h0;
    #1;
    tick();
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_starvation();
    test_same_addr();
    test_reset_during_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameters: ADDR_WIDTH, 16, address width; DATA_WIDTH, 16, data width; STARVE_LIMIT, 3, maximum consecutive write grants while a read waits (range 1..7).
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rd_req  input  1  operand-fetch read request; held high until rd_gnt is seen.
REQ-005 rd_addr  input  ADDR_WIDTH  read address; stable while rd_req is high.
REQ-006 rd_gnt  output  1  one-cycle pulse; read access occupies this cycle.
REQ-007 rd_data  output  DATA_WIDTH  read result; held until the next read completes.
REQ-008 rd_valid  output  1  one-cycle pulse, cycle after rd_gnt; rd_data is valid.
REQ-009 wr_req  input  1  write-back request; held high until wr_gnt is seen.
REQ-010 wr_addr  input  ADDR_WIDTH  write address; stable while wr_req is high.
REQ-011 wr_data  input  DATA_WIDTH  write data; stable while wr_req is high.
REQ-012 wr_gnt  output  1  one-cycle pulse; write access occupies this cycle.
REQ-013 addr_1  output  ADDR_WIDTH  data-SRAM address.
REQ-014 data_out  output  DATA_WIDTH  data-SRAM write data.
REQ-015 data_in  input  DATA_WIDTH  data-SRAM asynchronous read data.
REQ-016 we_n  output  1  data-SRAM write enable, active low.

Function
REQ-017 FSM states: IDLE, READ, WRITE. Each access state lasts exactly one cycle.
REQ-018 At every posedge, pending requests are sampled. Winner: next state READ or WRITE. No request: IDLE.
REQ-019 Address and data are registered at the accepting edge. addr_1, data_out and we_n are all registered and stay stable for the whole access cycle.
REQ-020 WRITE cycle: we_n=0, addr_1=wr_addr, data_out=wr_data, wr_gnt=1. All other cycles: we_n=1.
REQ-021 READ cycle: we_n=1, addr_1=rd_addr, rd_gnt=1. data_in is captured into rd_data at the edge that ends the cycle, and rd_valid=1 for the following cycle.
REQ-022 A requester that sees its gnt and has no further request SHALL drop req before the next edge. A req still high at that edge is a new request. Sustained throughput is one access per cycle.
REQ-023 Priority when both are pending: write wins, preserving store-before-load order. Exception: read wins when wr_streak equals STARVE_LIMIT.
REQ-024 wr_streak (3-bit):
  - increments on a write grant made while rd_req is high;
  - clears on any read grant, and on any cycle where rd_req is low;
  - saturates at STARVE_LIMIT.
REQ-025 Back-to-back writes with a read pending: at most STARVE_LIMIT write grants before the read is granted.
REQ-026 rd_gnt and wr_gnt are never high in the same cycle, except as REQ-031 allows.
REQ-027 IDLE: addr_1 and data_out hold their last values, we_n=1, no gnt.

Reset
REQ-028 reset_n low immediately forces:
  - state IDLE; any in-flight access is abandoned;
  - we_n=1, addr_1=0, data_out=0;
  - rd_gnt=0, wr_gnt=0, rd_valid=0, rd_data=0, wr_streak=0.
REQ-029 Arbitration resumes at the first posedge after reset_n deasserts. Requests that are high at that edge are accepted normally.

Configuration
REQ-030 Macro DMEM_ARB_BYPASS_EN controls same-address bypass.
REQ-031 With DMEM_ARB_BYPASS_EN defined: if both requests are pending at an edge with rd_addr==wr_addr and the write wins, the read is merged into the WRITE cycle:
  - rd_gnt and wr_gnt both pulse;
  - rd_data=wr_data with rd_valid the next cycle;
  - no separate READ cycle occurs;
  - wr_streak clears.
REQ-032 Without the macro: the same case takes a WRITE cycle followed by a READ cycle, and rd_data returns the written value from SRAM.

Verification
REQ-033 Single read: rd_req, rd_addr=0x0010, SRAM[0x10]=0xBEEF -> rd_gnt next cycle with addr_1=0x0010, we_n=1; rd_valid the following cycle with rd_data=0xBEEF.
REQ-034 Single write: wr_addr=0x0020, wr_data=0x1234 -> one cycle with we_n=0, addr_1=0x0020, data_out=0x1234, wr_gnt=1; SRAM[0x20]=0x1234.
REQ-035 Contention: rd_req and wr_req both high at one edge, different addresses -> WRITE, then READ, in consecutive cycles.
REQ-036 Starvation: rd_req held, four consecutive new wr_req, STARVE_LIMIT=3 -> sequence W,W,W,R,W.
REQ-037 Same address 0x0030, wr_data=0x5A5A, both requesting: with macro -> one cycle, both gnts, rd_data=0x5A5A. Without macro -> W then R, rd_data=0x5A5A.
REQ-038 reset_n low during a WRITE cycle -> we_n=1 and all gnts 0 immediately; IDLE after release.
